// File: rtl/alu_serial_ctrl_pkg.sv
// Shared op-code constants, FSM state encoding and op-classification helpers
// for the bit-serial ALU controller.
package alu_serial_ctrl_pkg;

  // ALUOp layout: [3] invert A, [2] negate/invert B (also the bit-0 carry-in),
  // [1:0] slice function (00 AND, 01 OR, 10 ADD).
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_NOR);
  endfunction

  function automatic logic is_arith_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_serial_ctrl_alu_1_bit.sv
// One-bit ALU slice: optional inversion of each operand, then AND, OR or full add.
module ALU_1_bit (
  input  logic [3:0] ALUOp,
  input  logic       a,
  input  logic       b,
  input  logic       CarryIn,
  output logic       Result,
  output logic       CarryOut
);

  logic a_eff;
  logic b_eff;

  assign a_eff = a ^ ALUOp[3];
  assign b_eff = b ^ ALUOp[2];

  // The carry is produced for every function so the controller can chain it
  // uniformly; it is only meaningful for ADD/SUB.
  assign CarryOut = (a_eff & b_eff) | (a_eff & CarryIn) | (b_eff & CarryIn);

  // NOTE: every always_comb output gets a value on every path (default arm
  // here) so no latch is inferred.
  always_comb begin
    unique case (ALUOp[1:0])
      2'b00:   Result = a_eff & b_eff;
      2'b01:   Result = a_eff | b_eff;
      2'b10:   Result = a_eff ^ b_eff ^ CarryIn;
      default: Result = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: shifts operands LSB first through a single
// ALU_1_bit slice, one bit per clock, and publishes result and flags at once.
module alu_serial_ctrl
  import alu_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             overflow,
  output logic             op_err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             op_err_q, op_err_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;

  logic             slice_res;
  logic             slice_cout;
  logic [WIDTH-1:0] res_full;

  ALU_1_bit u_slice (
    .ALUOp    (op_q),
    .a        (a_sh_q[0]),
    .b        (b_sh_q[0]),
    .CarryIn  (carry_q),
    .Result   (slice_res),
    .CarryOut (slice_cout)
  );

  // Result bits enter at the MSB and walk down, so after WIDTH shifts bit 0 is at position 0.
  assign res_full = {slice_res, res_sh_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_sh_d    = res_sh_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    op_err_d    = 1'b0;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_legal_op(op)) begin
            state_d  = ST_RUN;
            op_d     = op;
            a_sh_d   = a;
            b_sh_d   = b;
            res_sh_d = '0;
            cnt_d    = '0;
            carry_d  = op[2];
            busy_d   = 1'b1;
          end else begin
            op_err_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        res_sh_d = res_full;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = slice_cout;
        if (cnt_q == LAST_BIT) begin
          state_d     = ST_DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          result_d    = res_full;
          carry_out_d = slice_cout;
          zero_d      = (res_full == '0);
          // carry_q still holds the carry into the MSB during its slice cycle.
          overflow_d  = is_arith_op(op_q) ? (carry_q ^ slice_cout) : 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_sh_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      op_err_q    <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_sh_q    <= res_sh_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      op_err_q    <= op_err_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign op_err    = op_err_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed self-checking bench for alu_serial_ctrl at WIDTH=8 with
// hand-computed expected results.
module tb_alu_serial_ctrl;
  import alu_serial_ctrl_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         zero;
  logic         overflow;
  logic         op_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .zero      (zero),
    .overflow  (overflow),
    .op_err    (op_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Launch one operation, time the done pulse and check the published outputs.
  task automatic run_op(input string tag, input logic [3:0] o,
                        input logic [7:0] ia, input logic [7:0] ib,
                        input logic [7:0] exp_res, input bit chk_c, input logic exp_c,
                        input logic exp_z, input logic exp_v);
    int lat;
    @(negedge clk);
    start = 1'b1; op = o; a = ia; b = ib;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".busy_at_accept"}, 32'(busy), 32'd1);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, ".latency"}, 32'(lat), 32'd8);
    check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    check({tag, ".result"}, 32'(result), 32'(exp_res));
    if (chk_c) check({tag, ".carry_out"}, 32'(carry_out), 32'(exp_c));
    check({tag, ".zero"}, 32'(zero), 32'(exp_z));
    check({tag, ".overflow"}, 32'(overflow), 32'(exp_v));
    @(posedge clk); #1;
    check({tag, ".done_one_cycle"}, 32'(done), 32'd0);
    check({tag, ".result_held"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;
    int n_err;
    logic [7:0] res_at_done;

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.op_err", 32'(op_err), 32'd0);
    check("rst.outputs", {27'd0, result == 8'h00, carry_out, zero, overflow, 1'b0}, 32'b10000);
    @(negedge clk);
    reset = 1'b0;

    run_op("add_ff_01", OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    run_op("sub_05_07", OP_SUB, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("add_7f_01", OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op("nor_f0_0f", OP_NOR, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("and_f0_3c", OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("or_f0_3c",  OP_OR,  8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0);

    // Illegal op: one-cycle op_err, nothing else moves.
    @(negedge clk);
    start = 1'b1; op = 4'b0011; a = 8'h11; b = 8'h22;
    @(posedge clk); #1;
    start = 1'b0;
    check("illegal.op_err", 32'(op_err), 32'd1);
    check("illegal.busy", 32'(busy), 32'd0);
    check("illegal.result_kept", 32'(result), 32'h00FC);
    @(posedge clk); #1;
    check("illegal.op_err_pulse", 32'(op_err), 32'd0);
    check("illegal.busy_after", 32'(busy), 32'd0);

    // Second start during RUN must be ignored: C0 + 50 = 110 -> result 10, carry 1.
    @(negedge clk);
    start = 1'b1; op = OP_ADD; a = 8'hC0; b = 8'h50;
    @(posedge clk); #1;
    start = 1'b0;
    check("intrude.busy", 32'(busy), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = OP_SUB; a = 8'hFF; b = 8'h01;
    n_done = 0; n_err = 0; res_at_done = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    if (op_err) n_err++;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        n_done++;
        res_at_done = result;
      end
      if (op_err) n_err++;
    end
    check("intrude.done_count", 32'(n_done), 32'd1);
    check("intrude.op_err_count", 32'(n_err), 32'd0);
    check("intrude.result", 32'(res_at_done), 32'h0010);
    check("intrude.carry_out", 32'(carry_out), 32'd1);
    check("intrude.overflow", 32'(overflow), 32'd0);

    // Reset while bit 4 of an ADD is in the slice.
    @(negedge clk);
    start = 1'b1; op = OP_ADD; a = 8'h0F; b = 8'h01;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.op_err", 32'(op_err), 32'd0);
    check("abort.result", 32'(result), 32'd0);
    check("abort.flags", {29'd0, carry_out, zero, overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done || busy) n_done++;
    end
    check("abort.no_done_or_busy", 32'(n_done), 32'd0);

    run_op("after_abort_add", OP_ADD, 8'h55, 8'h0A, 8'h5F, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
